// File: rtl/ibex_regfile_scrub.sv
// Register-file scrubber: sits ahead of the RF write port and sweeps x1..xLAST to WordZeroVal on request.
// Optional macro IBEX_SCRUB_TWO_PASS_EN adds a preceding ~WordZeroVal pass (SWEEP then SWEEP2).
module ibex_regfile_scrub #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 scrub_req_i,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 we_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [4:0] Last = RV32E ? 5'd15 : 5'd31;

`ifdef IBEX_SCRUB_TWO_PASS_EN
  localparam logic [DataWidth-1:0] FirstPassVal = ~WordZeroVal;
`else
  localparam logic [DataWidth-1:0] FirstPassVal = WordZeroVal;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
`ifdef IBEX_SCRUB_TWO_PASS_EN
    SWEEP2,
`endif
    DONE
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [4:0]           r_cnt;
  logic [4:0]           w_cnt_nxt;
  logic                 r_pending;
  logic                 w_pending_nxt;
  logic                 w_busy;
  logic [4:0]           w_rf_waddr;
  logic [DataWidth-1:0] w_rf_wdata;
  logic                 w_rf_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_rf_waddr    = waddr_i;
    w_rf_wdata    = wdata_i;
    w_rf_we       = we_i;
    unique case (r_state)
      IDLE: begin
        if (scrub_req_i) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = 5'd1;
        end
      end
      SWEEP: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = r_cnt;
        w_rf_wdata = FirstPassVal;
        if (scrub_req_i) w_pending_nxt = 1'b1;
        if (r_cnt == Last) begin
`ifdef IBEX_SCRUB_TWO_PASS_EN
          w_state_nxt = SWEEP2;
          w_cnt_nxt   = 5'd1;
`else
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
`ifdef IBEX_SCRUB_TWO_PASS_EN
      SWEEP2: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = r_cnt;
        w_rf_wdata = WordZeroVal;
        if (scrub_req_i) w_pending_nxt = 1'b1;
        if (r_cnt == Last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
`endif
      DONE: begin
        // A request queued during the sweep, or arriving now, restarts without passing through IDLE.
        w_pending_nxt = 1'b0;
        if (r_pending || scrub_req_i) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = 5'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef IBEX_SCRUB_TWO_PASS_EN
  assign w_busy = (r_state == SWEEP) || (r_state == SWEEP2);
`else
  assign w_busy = (r_state == SWEEP);
`endif

  assign busy_o     = w_busy;
  assign done_o     = (r_state == DONE);
  assign err_o      = we_i & w_busy;
  assign rf_waddr_o = w_rf_waddr;
  assign rf_wdata_o = w_rf_wdata;
  assign rf_we_o    = w_rf_we;

endmodule

// File: tb/tb_ibex_regfile_scrub.sv
// Bench for ibex_regfile_scrub: RV32I and RV32E instances driven in parallel, checked against
// a schedule-of-writes reference model and a shadow register file.
module tb_ibex_regfile_scrub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        scrub_req_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;

  logic [4:0]  rf_waddr [2];
  logic [31:0] rf_wdata [2];
  logic        rf_we    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        err      [2];

  ibex_regfile_scrub #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0)) u_dut_rv32i (
    .clk_i(clk), .rst_i(rst_i), .scrub_req_i(scrub_req_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
    .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]), .rf_we_o(rf_we[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
  );

  ibex_regfile_scrub #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0)) u_dut_rv32e (
    .clk_i(clk), .rst_i(rst_i), .scrub_req_i(scrub_req_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
    .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]), .rf_we_o(rf_we[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
  );

`ifdef IBEX_SCRUB_TWO_PASS_EN
  localparam int Passes = 2;
`else
  localparam int Passes = 1;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: a FIFO of the writes still owed by the current sweep(s).
  logic [36:0] sched  [2][128];
  int          hd     [2];
  int          tl     [2];
  bit          m_done [2];
  bit          m_pend [2];
  logic [31:0] shadow [2][32];

  function automatic int last_of(input int d);
    return (d == 0) ? 31 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input int d);
    for (int p = 0; p < Passes; p++) begin
      for (int a = 1; a <= last_of(d); a++) begin
        sched[d][tl[d]] = {5'(a), (p == 0 && Passes == 2) ? 32'hFFFF_FFFF : 32'h0};
        tl[d] = (tl[d] + 1) % 128;
      end
    end
  endtask

  task automatic step(input bit r, input bit q, input bit w,
                      input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rst_i = r; scrub_req_i = q; we_i = w; waddr_i = wa; wdata_i = wd;
    #1;
    for (int d = 0; d < 2; d++) begin
      string       p;
      bit          eb;
      bit          ew;
      logic [4:0]  ea;
      logic [31:0] ed;
      int          dirty;
      p  = (d == 0) ? "rv32i" : "rv32e";
      eb = (hd[d] != tl[d]);
      if (eb) begin
        ew = 1'b1;
        {ea, ed} = sched[d][hd[d]];
      end else begin
        ew = w; ea = wa; ed = wd;
      end
      check({p, ".busy"},  32'(busy[d]), 32'(eb));
      check({p, ".done"},  32'(done[d]), 32'(m_done[d]));
      check({p, ".err"},   32'(err[d]),  32'(w & eb));
      check({p, ".we"},    32'(rf_we[d]), 32'(ew));
      if (ew) begin
        check({p, ".waddr"}, 32'(rf_waddr[d]), 32'(ea));
        check({p, ".wdata"}, rf_wdata[d], ed);
      end
      if (m_done[d]) begin
        dirty = 0;
        for (int a = 1; a <= last_of(d); a++) if (shadow[d][a] !== 32'h0) dirty++;
        check({p, ".sweep_clean"}, 32'(dirty), 32'h0);
      end
      if (rf_we[d]) shadow[d][rf_waddr[d]] = rf_wdata[d];
      // advance the model across the coming clock edge
      if (r) begin
        hd[d] = 0; tl[d] = 0; m_done[d] = 0; m_pend[d] = 0;
      end else if (eb) begin
        if (q) m_pend[d] = 1;
        hd[d] = (hd[d] + 1) % 128;
        if (hd[d] == tl[d]) m_done[d] = 1;
      end else begin
        if (q || (m_done[d] && m_pend[d])) load(d);
        m_pend[d] = 0;
        m_done[d] = 0;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; scrub_req_i = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    for (int d = 0; d < 2; d++) begin
      hd[d] = 0; tl[d] = 0; m_done[d] = 0; m_pend[d] = 0;
      for (int a = 0; a < 32; a++) shadow[d][a] = 32'hA5A5_A5A5;
    end

    step(1, 0, 0, 5'd0, 32'h0);
    step(1, 0, 1, 5'd3, 32'h1111_1111);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5'(i + 1), $urandom);
    // request with simultaneous core write, then core write at cnt=8, re-request at cnt=20
    step(0, 1, 1, 5'd7, 32'h1234_5678);
    for (int k = 1; k <= 31; k++) begin
      if (k == 8)       step(0, 0, 1, 5'd5, 32'hDEAD_BEEF);
      else if (k == 20) step(0, 1, 0, 5'd0, 32'h0);
      else              step(0, 0, 0, 5'd0, 32'h0);
    end
    for (int i = 0; i < 75; i++) step(0, 0, 0, 5'd0, 32'h0);
    // reset while cnt=12
    step(0, 1, 0, 5'd0, 32'h0);
    for (int k = 1; k < 12; k++) step(0, 0, 0, 5'd0, 32'h0);
    step(1, 0, 1, 5'd9, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 5'(i + 9), $urandom);

    for (int i = 0; i < 4000; i++) begin
      bit r, q, w;
      r = ($urandom % 300) == 0;
      q = ((m_done[0] || m_done[1]) && ($urandom % 2 == 1)) || (($urandom % 30) == 0);
      w = ($urandom % 2) == 1;
      step(r, q, w, 5'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ibex_regfile_scrub.md
IBEX_REGFILE_SCRUB -- requirements
Module: ibex_regfile_scrub

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RV32E, 0, selects 15 architectural GPRs instead of 31.
- DataWidth, 32, write-data width.
- WordZeroVal, '0, value the register file treats as cleared.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, the only clock.
- rst_i, in, 1, synchronous active-high reset.
- scrub_req_i, in, 1, request a full register-file clear.
- waddr_i, in, 5, core writeback address.
- wdata_i, in, DataWidth, core writeback data.
- we_i, in, 1, core writeback enable.
- rf_waddr_o, out, 5, register-file write address.
- rf_wdata_o, out, DataWidth, register-file write data.
- rf_we_o, out, 1, register-file write enable.
- busy_o, out, 1, sweep in progress; core must stall.
- done_o, out, 1, single-cycle pulse marking sweep completion.
- err_o, out, 1, core write attempted while busy.

REQ-003 One clock domain only: clk_i; reset rst_i is synchronous and active-high.

REQ-004 The block sits directly upstream of the register-file write port and drives its waddr/wdata/we inputs.

Function
REQ-005 FSM states SHALL be IDLE, SWEEP, SWEEP2 (present only with the REQ-020 macro) and DONE.

REQ-006 Let LAST = 15 when RV32E, else 31; sweep counter cnt SHALL be 5 bits and SHALL run 1..LAST, never addressing x0.

REQ-007 IDLE, DONE: rf_waddr_o/rf_wdata_o/rf_we_o SHALL equal waddr_i/wdata_i/we_i combinationally (pass-through).

REQ-008 IDLE with scrub_req_i=1 in cycle N SHALL go to SWEEP, with cnt=1 and busy_o=1 from cycle N+1.

REQ-009 SWEEP SHALL drive rf_we_o=1, rf_waddr_o=cnt, rf_wdata_o=WordZeroVal, then increment cnt each cycle.

REQ-010 At cnt=LAST, SWEEP SHALL go to DONE, or to SWEEP2 when the REQ-020 macro is defined.

REQ-011 DONE SHALL last exactly one cycle with done_o=1 and busy_o=0, then return to IDLE.

REQ-012 Without the REQ-020 macro, first sweep write is at N+1, last at N+LAST, done_o at N+LAST+1.

REQ-013 busy_o SHALL be 1 exactly in SWEEP and SWEEP2 and SHALL be decoded from registered state only.

REQ-014 A core write (we_i=1) in the same cycle as an accepted scrub_req_i in IDLE SHALL pass through unaltered; the following sweep then clears it.

REQ-015 Core write while busy_o=1:
- the write SHALL be dropped (never reaches rf_*);
- err_o SHALL be 1 in that same cycle (err_o = we_i & busy_o).

REQ-016 scrub_req_i=1 while busy_o=1 SHALL set a pending flag.
- In DONE with pending set, the next state SHALL be SWEEP (cnt=1) instead of IDLE, and pending SHALL clear.
- scrub_req_i in DONE SHALL likewise start a new sweep next cycle.

REQ-017 Because each register-file write both writes the idle physical entry and clears the old mapping, one complete sweep SHALL leave every non-x0 physical entry equal to WordZeroVal; sweeps SHALL therefore never be truncated.

Reset
REQ-018 rst_i=1 at any clock edge SHALL force:
- state=IDLE, cnt=0, pending=0;
- busy_o=0, done_o=0, err_o=0.

REQ-019 Reset mid-sweep SHALL abort without a done_o pulse; pass-through SHALL resume the cycle after reset deasserts.

Configuration
REQ-020 Macro IBEX_SCRUB_TWO_PASS_EN SHALL control a second sweep pass.
- Defined: SWEEP writes ~WordZeroVal to 1..LAST; SWEEP2 then writes WordZeroVal to 1..LAST; done_o is at N+2*LAST+1; busy spans both passes.
- Undefined: SWEEP2 and its logic are absent; single pass only.

Verification
REQ-021 RV32E=0, macro undefined, scrub_req_i pulse at cycle 10 -> busy_o=1 cycles 11..41, rf_waddr_o 1..31, rf_wdata_o=0; done_o=1 at 42 only.

REQ-022 RV32E=1, req at cycle 5 -> 15 writes to addresses 1..15 in cycles 6..20; done_o at 21.

REQ-023 we_i=1, waddr_i=5, wdata_i=32'hDEAD_BEEF at sweep cycle cnt=8 -> rf_waddr_o=8, rf_wdata_o=0, err_o=1 for that cycle only.

REQ-024 Second scrub_req_i at cnt=20 -> done_o pulse at the normal cycle; busy_o=1 the next cycle with rf_waddr_o=1; second done_o 32 cycles after the first.

REQ-025 rst_i=1 at cnt=12 -> next cycle busy_o=0, done_o never pulses, rf_we_o follows we_i.

REQ-026 IBEX_SCRUB_TWO_PASS_EN defined, RV32E=0, req at cycle 0 -> 31 writes of 32'hFFFF_FFFF, then 31 writes of 0 to 1..31; done_o at cycle 63.
